// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: holds the PC and issues one fetch at a time.
// Delivers the fetched word to decode, then waits for the next PC.
module ysyx_25020047_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dnpc_valid,
   input  logic [31:0] dnpc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        fetch_err,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT_RSP,
      S_HOLD,
      S_WAIT_NPC,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         // Responses are never sampled here, so stray replies are dropped.
         S_REQ: begin
            if (mem_req_ready) state_d = S_WAIT_RSP;
         end
         S_WAIT_RSP: begin
            if (mem_rsp_valid) begin
               if (mem_rsp_err) begin
                  inst_d  = '0;
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  inst_d  = mem_rsp_data;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (inst_ready) begin
               cnt_d   = cnt_q + 32'd1;
               state_d = S_WAIT_NPC;
            end
         end
         S_WAIT_NPC: begin
            if (dnpc_valid) begin
               pc_d = dnpc;
               if (dnpc[1:0] == 2'b00) begin
                  state_d = S_REQ;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end
            end
         end
         S_ERR: begin
         end
         default: state_d = S_ERR;
      endcase
   end

   assign mem_req_valid = (state_q == S_REQ);
   assign mem_addr      = pc_q;
   assign inst_valid    = (state_q == S_HOLD);
   assign inst          = inst_q;
   assign pc            = pc_q;
   assign fetch_err     = err_q;
   assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Scoreboard bench for ysyx_25020047_ifu: directed fetches, back-pressure,
// fault paths, counter wrap and mid-operation reset.
module tb_ysyx_25020047_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rst;
   logic        dnpc_valid;
   logic [31:0] dnpc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   ysyx_25020047_ifu #(.RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .dnpc_valid   (dnpc_valid),
      .dnpc         (dnpc),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_addr     (mem_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data (mem_rsp_data),
      .mem_rsp_err  (mem_rsp_err),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .pc           (pc),
      .fetch_err    (fetch_err),
      .fetch_cnt    (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors sample on the falling edge, where handshakes about to fire are visible.
   always @(negedge clk) begin
      if (!rst && mem_req_valid && mem_req_ready) begin
         if (addr_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
         end else begin
            logic [31:0] ea;
            ea = addr_q.pop_front();
            chk("req_addr", mem_addr, ea);
         end
      end
      if (!rst && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_inst", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("inst", inst, e.inst);
            chk("inst_pc", pc, e.pc);
            chk("inst_cnt", fetch_cnt, e.cnt);
         end
      end
   end

   // Accept a request at pc a, reply with data d; ends in HOLD.
   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [31:0] c);
      addr_q.push_back(a);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      exp_q.push_back('{inst: d, pc: a, cnt: c});
      tick();
      mem_rsp_valid = 1'b0;
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
   endtask

   task automatic consume();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   task automatic next_pc(input logic [31:0] n);
      dnpc_valid = 1'b1;
      dnpc       = n;
      tick();
      dnpc_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; dnpc_valid = 1'b0; dnpc = '0; mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0; inst_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_pc", pc, RST_PC);
      chk("rst_inst", inst, 32'h0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      chk("rst_cnt", fetch_cnt, 32'd0);
      chk("rst_req", {31'd0, mem_req_valid}, 32'd1);
      chk("rst_ivalid", {31'd0, inst_valid}, 32'd0);
      chk("rst_addr", mem_addr, RST_PC);

      // First fetch, then back-pressure from decode.
      fetch(RST_PC, 32'h0010_0093, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_inst", inst, 32'h0010_0093);
         chk("bp_pc", pc, RST_PC);
         chk("bp_cnt", fetch_cnt, 32'd0);
         chk("bp_noreq", {31'd0, mem_req_valid}, 32'd0);
      end
      consume();
      chk("cnt_one", fetch_cnt, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("npc_noreq", {31'd0, mem_req_valid}, 32'd0);
      end
      next_pc(32'h8000_0004);
      chk("npc_addr", mem_addr, 32'h8000_0004);
      chk("npc_req", {31'd0, mem_req_valid}, 32'd1);

      // Request stalled with a stray response pulse.
      for (int i = 0; i < 3; i++) begin
         mem_rsp_valid = (i == 1);
         mem_rsp_data  = 32'hBAD0_BAD0;
         tick();
         chk("stall_req", {31'd0, mem_req_valid}, 32'd1);
         chk("stall_addr", mem_addr, 32'h8000_0004);
      end
      addr_q.push_back(32'h8000_0004);
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      chk("wait_rsp_noiv", {31'd0, inst_valid}, 32'd0);
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h0020_8113;
      exp_q.push_back('{inst: 32'h0020_8113, pc: 32'h8000_0004, cnt: 32'd1});
      tick();
      mem_rsp_valid = 1'b0;
      chk("late_inst", inst, 32'h0020_8113);
      // dnpc_valid alongside inst_ready must not move the PC.
      inst_ready = 1'b1;
      dnpc_valid = 1'b1;
      dnpc       = 32'h8000_0100;
      tick();
      inst_ready = 1'b0;
      dnpc_valid = 1'b0;
      chk("hold_dnpc_pc", pc, 32'h8000_0004);
      chk("cnt_two", fetch_cnt, 32'd2);
      next_pc(32'h8000_0008);

      // Counter wrap via a preloaded count.
      force dut.cnt_q = 32'hFFFF_FFFF;
      tick();
      release dut.cnt_q;
      #1;
      fetch(32'h8000_0008, 32'h0000_0013, 32'hFFFF_FFFF);
      consume();
      chk("cnt_wrap", fetch_cnt, 32'd0);
      next_pc(32'h8000_000C);

      // Reset while waiting on a response, then a late reply.
      addr_q.push_back(32'h8000_000C);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0;
      tick();
      mem_rsp_valid = 1'b0;
      chk("mrst_req", {31'd0, mem_req_valid}, 32'd1);
      chk("mrst_pc", pc, RST_PC);
      chk("mrst_inst", inst, 32'h0);
      chk("mrst_iv", {31'd0, inst_valid}, 32'd0);

      // Access fault on the response.
      addr_q.push_back(RST_PC);
      mem_req_ready = 1'b1;
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_err   = 1'b1;
      mem_rsp_data  = 32'h1234_5678;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      chk("err_flag", {31'd0, fetch_err}, 32'd1);
      chk("err_inst", inst, 32'h0);
      dnpc_valid = 1'b1;
      dnpc       = 32'h8000_0040;
      inst_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("err_noreq", {31'd0, mem_req_valid}, 32'd0);
         chk("err_noiv", {31'd0, inst_valid}, 32'd0);
      end
      dnpc_valid = 1'b0;
      inst_ready = 1'b0;
      mem_req_ready = 1'b0;
      chk("err_pc", pc, RST_PC);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rec_err", {31'd0, fetch_err}, 32'd0);
      chk("rec_pc", pc, RST_PC);
      chk("rec_req", {31'd0, mem_req_valid}, 32'd1);

      // Misaligned next PC.
      fetch(RST_PC, 32'h0000_0093, 32'd0);
      consume();
      next_pc(32'h8000_0006);
      chk("mis_err", {31'd0, fetch_err}, 32'd1);
      chk("mis_pc", pc, 32'h8000_0006);
      mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mis_noreq", {31'd0, mem_req_valid}, 32'd0);
      end
      mem_req_ready = 1'b0;

      chk("addr_q_left", addr_q.size(), 32'd0);
      chk("exp_q_left", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
